// File: rtl/punc_defs_pkg.sv
// PUnC (LC-3) ISA constants shared by the operand-fetch stage and its decoder.
package punc_defs;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam int OPCODE_MSB   = 15;
  localparam int OPCODE_LSB   = 12;
  localparam int DR_MSB       = 11;
  localparam int DR_LSB       = 9;
  localparam int SR1_MSB      = 8;
  localparam int SR1_LSB      = 6;
  localparam int SR2_MSB      = 2;
  localparam int SR2_LSB      = 0;
  localparam int IMM_FLAG_BIT = 5;
  localparam int JSR_MODE_BIT = 11;

  localparam logic [2:0] REG_R7 = 3'd7;

endpackage

// File: rtl/operand_decode.sv
// Combinational register-field decode of one PUnC instruction word.
module operand_decode
  import punc_defs::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] sr1,
  output logic [ADDR_WIDTH-1:0] sr2,
  output logic [ADDR_WIDTH-1:0] st_sr,
  output logic [ADDR_WIDTH-1:0] dr,
  output logic                  use_sr1,
  output logic                  use_sr2,
  output logic                  use_st,
  output logic                  writes
);

  logic [3:0] opcode;
  logic       imm_mode;
  logic       jsr_pc_rel;
  logic       unused_bits;

  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign imm_mode    = instr[IMM_FLAG_BIT];
  assign jsr_pc_rel  = instr[JSR_MODE_BIT];
  assign sr1         = instr[SR1_MSB:SR1_LSB];
  assign sr2         = instr[SR2_MSB:SR2_LSB];
  assign st_sr       = instr[DR_MSB:DR_LSB];
  assign unused_bits = ^instr[4:3];

  always_comb begin
    use_sr1 = 1'b0;
    use_sr2 = 1'b0;
    use_st  = 1'b0;
    writes  = 1'b0;
    dr      = '0;
    case (opcode)
      OP_ADD, OP_AND: begin
        use_sr1 = 1'b1;
        use_sr2 = !imm_mode;
        writes  = 1'b1;
        dr      = instr[DR_MSB:DR_LSB];
      end
      OP_NOT, OP_LDR: begin
        use_sr1 = 1'b1;
        writes  = 1'b1;
        dr      = instr[DR_MSB:DR_LSB];
      end
      OP_LD, OP_LDI, OP_LEA: begin
        writes = 1'b1;
        dr     = instr[DR_MSB:DR_LSB];
      end
      OP_JMP: use_sr1 = 1'b1;
      // JSRR takes its target from BaseR; plain JSR is PC-relative.
      OP_JSR: begin
        use_sr1 = !jsr_pc_rel;
        writes  = 1'b1;
        dr      = REG_R7;
      end
      OP_TRAP: begin
        writes = 1'b1;
        dr     = REG_R7;
      end
      OP_ST, OP_STI: use_st = 1'b1;
      OP_STR: begin
        use_sr1 = 1'b1;
        use_st  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: decodes register fields, reads the register file, and holds a
// one-entry operand bundle for execute behind a busy-bit scoreboard.
module operand_fetch
  import punc_defs::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int N_REGS     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [ADDR_WIDTH-1:0] rf_r_addr_0,
  output logic [ADDR_WIDTH-1:0] rf_r_addr_1,
  output logic [ADDR_WIDTH-1:0] rf_r_addr_2,
  input  logic [DATA_WIDTH-1:0] rf_r_data_0,
  input  logic [DATA_WIDTH-1:0] rf_r_data_1,
  input  logic [DATA_WIDTH-1:0] rf_r_data_2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2,
  output logic [DATA_WIDTH-1:0] out_src_st,
  output logic [ADDR_WIDTH-1:0] out_dr,
  output logic                  out_wr
);

  logic [ADDR_WIDTH-1:0] sr1, sr2, st_sr, dr;
  logic                  use_sr1, use_sr2, use_st, writes;
  logic                  hazard, fire;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_src1_q, out_src1_d;
  logic [DATA_WIDTH-1:0] out_src2_q, out_src2_d;
  logic [DATA_WIDTH-1:0] out_src_st_q, out_src_st_d;
  logic [ADDR_WIDTH-1:0] out_dr_q, out_dr_d;
  logic                  out_wr_q, out_wr_d;
  logic [N_REGS-1:0]     busy_q, busy_d;

  operand_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .instr  (in_instr),
    .sr1    (sr1),
    .sr2    (sr2),
    .st_sr  (st_sr),
    .dr     (dr),
    .use_sr1(use_sr1),
    .use_sr2(use_sr2),
    .use_st (use_st),
    .writes (writes)
  );

  assign rf_r_addr_0 = use_sr1 ? sr1   : '0;
  assign rf_r_addr_1 = use_sr2 ? sr2   : '0;
  assign rf_r_addr_2 = use_st  ? st_sr : '0;

  assign hazard = in_valid && ((use_sr1 && busy_q[sr1]) ||
                               (use_sr2 && busy_q[sr2]) ||
                               (use_st  && busy_q[st_sr]) ||
                               (writes  && busy_q[dr]));

  assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
  assign fire     = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_src1_d   = out_src1_q;
    out_src2_d   = out_src2_q;
    out_src_st_d = out_src_st_q;
    out_dr_d     = out_dr_q;
    out_wr_d     = out_wr_q;
    busy_d       = busy_q;

    if (flush)          out_valid_d = 1'b0;
    else if (fire)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    if (fire) begin
      out_instr_d  = in_instr;
      out_pc_d     = in_pc;
      out_src1_d   = use_sr1 ? rf_r_data_0 : '0;
      out_src2_d   = use_sr2 ? rf_r_data_1 : '0;
      out_src_st_d = use_st  ? rf_r_data_2 : '0;
      out_dr_d     = dr;
      out_wr_d     = writes;
    end

    // Clears first so a same-edge set on the same register wins.
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (flush && out_valid_q && out_wr_q) busy_d[out_dr_q] = 1'b0;
    if (fire && writes) busy_d[dr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_src1_q   <= '0;
      out_src2_q   <= '0;
      out_src_st_q <= '0;
      out_dr_q     <= '0;
      out_wr_q     <= 1'b0;
      busy_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_src1_q   <= out_src1_d;
      out_src2_q   <= out_src2_d;
      out_src_st_q <= out_src_st_d;
      out_dr_q     <= out_dr_d;
      out_wr_q     <= out_wr_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;
  assign out_src1   = out_src1_q;
  assign out_src2   = out_src2_q;
  assign out_src_st = out_src_st_q;
  assign out_dr     = out_dr_q;
  assign out_wr     = out_wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 8-entry register file.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_valid, flush, out_valid, out_ready, out_wr;
  logic [15:0] in_instr, in_pc, rf_r_data_0, rf_r_data_1, rf_r_data_2;
  logic [15:0] out_instr, out_pc, out_src1, out_src2, out_src_st;
  logic [2:0]  rf_r_addr_0, rf_r_addr_1, rf_r_addr_2, wb_addr, out_dr;
  logic [15:0] rf [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_r_data_0 = rf[rf_r_addr_0];
  assign rf_r_data_1 = rf[rf_r_addr_1];
  assign rf_r_data_2 = rf[rf_r_addr_2];

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rf_r_addr_0(rf_r_addr_0), .rf_r_addr_1(rf_r_addr_1), .rf_r_addr_2(rf_r_addr_2),
    .rf_r_data_0(rf_r_data_0), .rf_r_data_1(rf_r_data_1), .rf_r_data_2(rf_r_data_2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2),
    .out_src_st(out_src_st), .out_dr(out_dr), .out_wr(out_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-back: busy clears at the edge and the register file updates with it.
  task automatic do_wb(input logic [2:0] addr, input logic [15:0] data);
    wb_valid = 1'b1;
    wb_addr  = addr;
    tick();
    rf[addr] = data;
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0;
    wb_valid = 1'b0; wb_addr = 3'd0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++;
    if ({out_instr, out_pc, out_src1, out_src2, out_src_st, out_dr, out_wr} !== 84'h0) begin
      errors++; $display("FAIL reset_bundle got %h/%h/%h/%h/%h/%h/%b want all 0",
                         out_instr, out_pc, out_src1, out_src2, out_src_st, out_dr, out_wr);
    end
    checks++;
    if (dut.busy_q !== 8'h00) begin errors++; $display("FAIL reset_busy got %h want 00", dut.busy_q); end
  endtask

  task automatic test_decode();
    logic [15:0] instrs [6] = '{16'h94FF, 16'h4080, 16'hC1C0, 16'hB601, 16'h5AC5, 16'hF025};
    logic [8:0]  addrs  [6] = '{{3'd3, 3'd0, 3'd0}, {3'd2, 3'd0, 3'd0}, {3'd7, 3'd0, 3'd0},
                                {3'd0, 3'd0, 3'd3}, {3'd3, 3'd5, 3'd0}, {3'd0, 3'd0, 3'd0}};
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_instr = instrs[i];
      #1;
      checks++;
      if ({rf_r_addr_0, rf_r_addr_1, rf_r_addr_2} !== addrs[i]) begin
        errors++; $display("FAIL decode_addr instr %h got %0d/%0d/%0d want %0d/%0d/%0d", instrs[i],
                           rf_r_addr_0, rf_r_addr_1, rf_r_addr_2, addrs[i][8:6], addrs[i][5:3], addrs[i][2:0]);
      end
    end
  endtask

  task automatic test_add();
    rf[2] = 16'd5; rf[3] = 16'd7;
    in_valid = 1'b1; in_instr = 16'h1283; in_pc = 16'h0101; out_ready = 1'b1;
    #1;
    checks++;
    if ({rf_r_addr_0, rf_r_addr_1, rf_r_addr_2, in_ready} !== {3'd2, 3'd3, 3'd0, 1'b1}) begin
      errors++; $display("FAIL add_issue got addr %0d/%0d/%0d ready %b want 2/3/0 ready 1",
                         rf_r_addr_0, rf_r_addr_1, rf_r_addr_2, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_src1, out_src2, out_dr, out_wr, out_pc} !== {1'b1, 16'd5, 16'd7, 3'd1, 1'b1, 16'h0101}) begin
      errors++; $display("FAIL add_bundle got v%b s1 %h s2 %h dr %0d wr %b pc %h want v1 0005 0007 1 1 0101",
                         out_valid, out_src1, out_src2, out_dr, out_wr, out_pc);
    end
    checks++;
    if (dut.busy_q !== 8'h02) begin errors++; $display("FAIL add_busy got %h want 02", dut.busy_q); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", out_valid); end
  endtask

  task automatic test_raw_hazard();
    in_valid = 1'b1; in_instr = 16'h1861; in_pc = 16'h0102;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b want 0", in_ready); end
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++; $display("FAIL raw_stall_hold got ready %b valid %b want 0 0", in_ready, out_valid);
    end
    wb_valid = 1'b1; wb_addr = 3'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %b want 0", in_ready); end
    tick();
    rf[1] = 16'h0042;
    wb_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_src1, out_src2, out_dr} !== {1'b1, 16'h0042, 16'h0000, 3'd4}) begin
      errors++; $display("FAIL raw_bundle got v%b s1 %h s2 %h dr %0d want v1 0042 0000 4",
                         out_valid, out_src1, out_src2, out_dr);
    end
    checks++;
    if (dut.busy_q !== 8'h10) begin errors++; $display("FAIL raw_busy got %h want 10", dut.busy_q); end
    do_wb(3'd4, 16'h0043);
  endtask

  task automatic test_back_to_back();
    rf[0] = 16'h1111; rf[2] = 16'd5;
    in_valid = 1'b1; in_instr = 16'h1021; in_pc = 16'h0200; out_ready = 1'b1;
    #1;
    checks++;
    if ({rf_r_addr_1, in_ready} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL imm_issue got addr1 %0d ready %b want 0 1", rf_r_addr_1, in_ready);
    end
    tick();
    in_instr = 16'h12A0; in_pc = 16'h0201;
    #1;
    checks++;
    if ({out_valid, out_src1, out_src2, out_dr} !== {1'b1, 16'h1111, 16'h0000, 3'd0}) begin
      errors++; $display("FAIL imm_bundle got v%b s1 %h s2 %h dr %0d want v1 1111 0000 0",
                         out_valid, out_src1, out_src2, out_dr);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_src1, out_src2, out_dr} !== {1'b1, 16'h12A0, 16'd5, 16'h0000, 3'd1}) begin
      errors++; $display("FAIL b2b_bundle got v%b i %h s1 %h s2 %h dr %0d want v1 12a0 0005 0000 1",
                         out_valid, out_instr, out_src1, out_src2, out_dr);
    end
    checks++;
    if (dut.busy_q !== 8'h03) begin errors++; $display("FAIL b2b_busy got %h want 03", dut.busy_q); end
    do_wb(3'd0, 16'h1112);
    do_wb(3'd1, 16'h0006);
    checks++;
    if (dut.busy_q !== 8'h00) begin errors++; $display("FAIL b2b_wb_clear got %h want 00", dut.busy_q); end
  endtask

  task automatic test_store();
    rf[5] = 16'hBEEF; rf[6] = 16'h3000;
    in_valid = 1'b1; in_instr = 16'h7B82; in_pc = 16'h0300;
    #1;
    checks++;
    if ({rf_r_addr_0, rf_r_addr_1, rf_r_addr_2, in_ready} !== {3'd6, 3'd0, 3'd5, 1'b1}) begin
      errors++; $display("FAIL str_issue got addr %0d/%0d/%0d ready %b want 6/0/5 ready 1",
                         rf_r_addr_0, rf_r_addr_1, rf_r_addr_2, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_src1, out_src2, out_src_st, out_wr} !== {16'h3000, 16'h0000, 16'hBEEF, 1'b0}) begin
      errors++; $display("FAIL str_bundle got s1 %h s2 %h st %h wr %b want 3000 0000 beef 0",
                         out_src1, out_src2, out_src_st, out_wr);
    end
    checks++;
    if (dut.busy_q !== 8'h00) begin errors++; $display("FAIL str_busy got %h want 00", dut.busy_q); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'hE605; in_pc = 16'h0400;
    tick();
    in_instr = 16'h3A01; in_pc = 16'h0401;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b want 0", i, in_ready); end
      tick();
      checks++;
      if ({out_valid, out_instr, out_pc} !== {1'b1, 16'hE605, 16'h0400}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v%b i %h pc %h want v1 e605 0400",
                           i, out_valid, out_instr, out_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_src_st, out_wr} !== {1'b1, 16'h3A01, 16'hBEEF, 1'b0}) begin
      errors++; $display("FAIL bp_next got v%b i %h st %h wr %b want v1 3a01 beef 0",
                         out_valid, out_instr, out_src_st, out_wr);
    end
    checks++;
    if (dut.busy_q !== 8'h08) begin errors++; $display("FAIL bp_busy got %h want 08", dut.busy_q); end
    do_wb(3'd3, 16'h0405);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h4802; in_pc = 16'h0500;
    #1;
    checks++;
    if (rf_r_addr_0 !== 3'd0) begin errors++; $display("FAIL jsr_addr0 got %0d want 0", rf_r_addr_0); end
    tick();
    in_instr = 16'h3A01; flush = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_dr, out_wr} !== {1'b0, 1'b1, 3'd7, 1'b1}) begin
      errors++; $display("FAIL flush_cycle got ready %b v%b dr %0d wr %b want 0 1 7 1",
                         in_ready, out_valid, out_dr, out_wr);
    end
    checks++;
    if (dut.busy_q !== 8'h80) begin errors++; $display("FAIL jsr_busy got %h want 80", dut.busy_q); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, dut.busy_q} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL flush_result got v%b busy %h want v0 00", out_valid, dut.busy_q);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h2201; in_pc = 16'h0600;
    tick();
    in_instr = 16'h1861;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_ready got %b want 0", in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ({out_valid, out_instr, out_src1, dut.busy_q} !== {1'b0, 16'h0, 16'h0, 8'h00}) begin
      errors++; $display("FAIL rst_mid got v%b i %h s1 %h busy %h want v0 0000 0000 00",
                         out_valid, out_instr, out_src1, dut.busy_q);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_add();
    test_raw_hazard();
    test_back_to_back();
    test_store();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue-side stage directly upstream of the 3-read/1-write register file.
- Accepts one 16-bit instruction per cycle over a valid/ready handshake and decodes register fields per the PUnC (LC-3) ISA.
- Drives the three register-file read addresses and captures the operands into a single-entry output register for execute.
- Holds a busy-bit scoreboard over pending writes and stalls on RAW/WAW hazards until write-back clears them.

Parameters:
- DATA_WIDTH, 16, operand/instruction/PC width.
- ADDR_WIDTH, 3, register address width.
- N_REGS, 8, number of architectural registers; scoreboard width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  DATA_WIDTH  instruction word.
- in_pc  in  DATA_WIDTH  PC of instruction (+1 already applied upstream).
- rf_r_addr_0  out  ADDR_WIDTH  SR1/BaseR address.
- rf_r_addr_1  out  ADDR_WIDTH  SR2 address.
- rf_r_addr_2  out  ADDR_WIDTH  store-source SR address.
- rf_r_data_0/1/2  in  DATA_WIDTH each  combinational read data.
- wb_valid  in  1  register-file write occurring this edge.
- wb_addr  in  ADDR_WIDTH  register being written.
- flush  in  1  discard held instruction.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_instr, out_pc, out_src1, out_src2, out_src_st  out  DATA_WIDTH each  registered bundle.
- out_dr  out  ADDR_WIDTH  destination register.
- out_wr  out  1  instruction writes a register.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, all bundle outputs=0, busy[N_REGS-1:0]=0. Reset overrides flush, wb and handshake.
- Decode on opcode = in_instr[15:12]. Decode is combinational and uses the raw in_instr.
  - SR1 = [8:6]; used by ADD, AND, NOT, JMP, JSRR (JSR with bit11=0), LDR, STR.
  - SR2 = [2:0]; used by ADD and AND when bit5=0.
  - Store source = [11:9]; used by ST, STI, STR.
  - DR = [11:9]; written by ADD, AND, NOT, LD, LDI, LDR, LEA.
  - DR = 7 for JSR, JSRR and TRAP.
  - No register write for BR, JMP, ST, STI, STR, RTI or reserved.
- Read addresses are driven from decode every cycle. Unused ports are driven to 0.
- hazard = in_valid && (any used source has its busy bit set, or (writes && busy[DR])).
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Fire = in_valid && in_ready. On fire, at the next edge:
  - load instr, pc and the three rf_r_data values into the bundle; unused operands load 0;
  - set out_valid=1;
  - if the instruction writes, set busy[DR].
- Latency: one cycle from fire to out_valid.
- Back-to-back issue at full throughput when there is no hazard and out_ready=1.
- When out_valid && !out_ready && !flush, the bundle holds stable.
- out_valid clears when out_ready is high and there is no fire.
- wb_valid clears busy[wb_addr] at the edge. No forwarding is needed: the register file writes at the same edge, so the next-cycle read returns the new value. A stalled instruction therefore issues one cycle after wb clears the hazard.
- Simultaneous set and clear on the same register: set wins.
- flush:
  - out_valid clears next edge;
  - if the held bundle had out_wr=1, its busy[out_dr] clears (unless set by a same-edge fire, which flush blocks anyway);
  - in_ready=0 that cycle.
- Decoding is purely a function of in_instr. busy bits never change except via fire, wb and flush.

Decomposition:
- Shared package (punc_defs) holds:
  - opcode localparams (ADD=0001, AND=0101, BR=0000, JMP=1100, JSR=0100, LD=0010, LDI=1010, LDR=0110, LEA=1110, NOT=1001, RTI=1000, ST=0011, STI=1011, STR=0111, TRAP=1111);
  - field bit-position constants;
  - the R7 link-register constant.
- One combinational sub-module, operand_decode: in_instr -> sr1, sr2, st_sr, dr, use_sr1, use_sr2, use_st, writes.

Test Plan:
- Reset then issue ADD R1,R2,R3 (0x1283) with R2=5, R3=7, out_ready=1 -> next cycle out_valid=1, out_src1=5, out_src2=7, out_dr=1, busy[1]=1.
- ADD R1,... then ADD R4,R1,#1 (0x1861) with no wb -> in_ready=0. Pulse wb_valid/wb_addr=1 -> in_ready=1 the cycle after the wb edge, and out_src1 equals the written value.
- ADD immediate 0x1021 (bit5=1) -> rf_r_addr_1=0, out_src2=0, R0 not checked for SR2 hazard.
- STR R5,R6,#2 (0x7B82) with R5=0xBEEF, R6=0x3000 -> out_src1=0x3000, out_src_st=0xBEEF, out_wr=0, busy unchanged.
- out_ready held 0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0. Raise out_ready -> next instruction loads the following edge.
- JSR (0x4802) held in output, then flush=1 -> out_valid=0 next cycle, busy[7]=0. rst mid-stall -> all busy=0, out_valid=0.
